byte_serializer: RTL and testbench

Downstream stage of the 8-bit shift stage. It accepts a parallel byte over a valid/ready handshake and transmits it as a framed serial bitstream: start bit, 8 data bits LSB-first, optional parity, stop bit. Each bit is held for a programmable number of clock cycles. It is the last stage before the serial pin or the serial-capture side of the bench.

---
 rtl/byte_serializer_pkg.sv | 21 ++
 rtl/byte_serializer_bit_period.sv | 27 ++
 rtl/byte_serializer.sv | 107 ++++++++++
 tb/tb_byte_serializer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/byte_serializer_pkg.sv
// Shared types and line levels for the byte serializer.
package byte_serializer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/byte_serializer_bit_period.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// bit_end marks the last cycle of each serial bit.
module bit_period_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_end
);
   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!run || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Byte-to-serial framer: start, 8 data bits LSB-first, optional parity, stop.
// Accepts only in IDLE; all outputs are registered.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       ser_out,
   output logic       busy,
   output logic       done
);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   state_t     state;
   logic [7:0] shreg;
   logic [2:0] bitcnt;
   logic       par;
   logic       bit_end;

   bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_period (
      .clk     (clk),
      .rst     (rst),
      .run     (state != IDLE),
      .bit_end (bit_end)
   );

   // ser_out is set on the edge that enters each state so the line is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ser_out  <= IDLE_LEVEL;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b1;
         shreg    <= '0;
         bitcnt   <= '0;
         par      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shreg    <= in_data;
                  par      <= calc_parity(in_data, PARITY_ODD);
                  bitcnt   <= '0;
                  state    <= START;
                  ser_out  <= START_LEVEL;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  ser_out <= shreg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shreg  <= shreg >> 1;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == LAST_BIT) begin
                     if (PARITY_EN) begin
                        state   <= PARITY;
                        ser_out <= par;
                     end else begin
                        state   <= STOP;
                        ser_out <= STOP_LEVEL;
                     end
                  end else begin
                     ser_out <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state   <= STOP;
                  ser_out <= STOP_LEVEL;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state    <= IDLE;
                  ser_out  <= IDLE_LEVEL;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  done     <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               ser_out  <= IDLE_LEVEL;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer across four parameter sets.
module tb_byte_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld [4];
   logic [7:0] dat [4];
   logic       rdy [4];
   logic       ser [4];
   logic       bsy [4];
   logic       dn  [4];

   int cpb [4] = '{4, 4, 4, 1};
   int pen [4] = '{1, 1, 0, 1};

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   byte_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
      .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
   byte_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
      .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
   byte_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
      .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(dat[2]), .in_ready(rdy[2]),
      .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));
   byte_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_fast (
      .clk(clk), .rst(rst), .in_valid(vld[3]), .in_data(dat[3]), .in_ready(rdy[3]),
      .ser_out(ser[3]), .busy(bsy[3]), .done(dn[3]));

   task automatic chk(input string tag, input logic obs, input logic expv);
      total = total + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   // mode 0: single pulse of in_valid; mode 1: valid held with churning data;
   // mode 2: valid held and next byte presented in the done cycle (back-to-back).
   // pre=1 means the accept is already being driven by the previous frame.
   task automatic frame(input int i, input logic [7:0] b, input logic ep, input int mode,
                        input logic [7:0] nb, input bit pre, input string tag);
      int   nbits;
      logic expb;
      nbits = 10 + pen[i];
      if (!pre) begin
         @(negedge clk);
         vld[i] = 1'b1;
         dat[i] = b;
         chk({tag, "_rdy_pre"}, rdy[i], 1'b1);
      end
      for (int k = 0; k < nbits; k++) begin
         for (int c = 0; c < cpb[i]; c++) begin
            @(negedge clk);
            if (mode == 0 && k == 0 && c == 0) vld[i] = 1'b0;
            if (mode == 1) dat[i] = 8'($urandom);
            if (mode == 1 && k == nbits - 1 && c == cpb[i] - 1) vld[i] = 1'b0;
            if (k == 0)                  expb = 1'b0;
            else if (k <= 8)             expb = b[k-1];
            else if (k == 9 && pen[i] != 0) expb = ep;
            else                         expb = 1'b1;
            chk($sformatf("%s_bit%0d_c%0d", tag, k, c), ser[i], expb);
            chk($sformatf("%s_busy%0d_c%0d", tag, k, c), bsy[i], 1'b1);
            chk($sformatf("%s_rdy%0d_c%0d", tag, k, c), rdy[i], 1'b0);
            chk($sformatf("%s_done%0d_c%0d", tag, k, c), dn[i], 1'b0);
         end
      end
      @(negedge clk);
      chk({tag, "_done"}, dn[i], 1'b1);
      chk({tag, "_done_rdy"}, rdy[i], 1'b1);
      chk({tag, "_done_busy"}, bsy[i], 1'b0);
      chk({tag, "_done_idle_line"}, ser[i], 1'b1);
      if (mode == 2) dat[i] = nb;
      if (mode == 1) begin
         @(negedge clk);
         chk({tag, "_no_extra_accept"}, bsy[i], 1'b0);
         chk({tag, "_done_cleared"}, dn[i], 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld[i] = 1'b0;
         dat[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_ser%0d", i), ser[i], 1'b1);
         chk($sformatf("reset_busy%0d", i), bsy[i], 1'b0);
         chk($sformatf("reset_done%0d", i), dn[i], 1'b0);
         chk($sformatf("reset_rdy%0d", i), rdy[i], 1'b1);
      end
      rst = 1'b0;

      // 0xA5: even parity bit 0, done 45 cycles after accept
      frame(0, 8'hA5, 1'b0, 0, 8'h00, 1'b0, "a5_even");
      frame(0, 8'h01, 1'b1, 0, 8'h00, 1'b0, "p01_even");
      frame(1, 8'h01, 1'b0, 0, 8'h00, 1'b0, "p01_odd");
      frame(2, 8'h01, 1'b0, 0, 8'h00, 1'b0, "p01_nopar");

      // back-to-back, one idle-high cycle (the done cycle) between frames
      frame(0, 8'h00, 1'b0, 2, 8'hFF, 1'b0, "b2b_00");
      frame(0, 8'hFF, 1'b0, 0, 8'h00, 1'b1, "b2b_ff");

      frame(0, 8'h3C, 1'b0, 1, 8'h00, 1'b0, "holdoff_3c");

      // abort 0x5A during D3 (cycles 17..20 after accept)
      @(negedge clk);
      vld[0] = 1'b1;
      dat[0] = 8'h5A;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("abort_busy_before", bsy[0], 1'b1);
      chk("abort_d3_bit", ser[0], 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_ser", ser[0], 1'b1);
      chk("abort_busy", bsy[0], 1'b0);
      chk("abort_rdy", rdy[0], 1'b1);
      chk("abort_done", dn[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk($sformatf("abort_no_done%0d", n), dn[0], 1'b0);
         chk($sformatf("abort_idle_busy%0d", n), bsy[0], 1'b0);
      end
      frame(0, 8'h81, 1'b0, 0, 8'h00, 1'b0, "after_rst_81");

      // one cycle per bit, done in cycle 12
      frame(3, 8'hC3, 1'b0, 0, 8'h00, 1'b0, "fast_c3");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
